// File: rtl/instr_sequencer_if.sv
// Issue-side handshake bundle between the instruction sequencer (master) and
// the consuming core or bench (slave).
interface instr_sequencer_if #(
   parameter int XLEN = 32
);
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instruction;
   logic [XLEN-1:0] issue_pc;

   modport master (output instr_valid, output instruction, output issue_pc, input instr_ready);
   modport slave  (input instr_valid, input instruction, input issue_pc, output instr_ready);
endinterface

// File: rtl/instr_sequencer.sv
// Program-buffer instruction sequencer: one instruction + byte PC per valid/ready handshake.
// Define NOP_FILL_EN to drive addi x0,x0,0 on instruction whenever instr_valid is low.
module instr_sequencer #(
   parameter int              XLEN    = 32,
   parameter int              DEPTH   = 16,
   localparam int             AW      = $clog2(DEPTH),
   parameter logic [XLEN-1:0] PC_BASE = '0,
   parameter int              CNT_W   = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [XLEN-1:0]  load_data,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_mode,
   input  logic [AW:0]      prog_len,
   instr_sequencer_if.master bus,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] issue_count
);

`ifdef NOP_FILL_EN
   localparam logic [XLEN-1:0] FILL = XLEN'(32'h0000_0013);
`else
   localparam logic [XLEN-1:0] FILL = '0;
`endif
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
   localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   logic [XLEN-1:0]  mem [DEPTH];
   state_t           state, state_n;
   logic [AW-1:0]    idx, idx_n;
   logic [AW:0]      len, len_n;
   logic             loop_q, loop_n;
   logic [CNT_W-1:0] cnt_n;
   logic             valid_q, valid_n;
   logic [XLEN-1:0]  instr_q, instr_n;
   logic [XLEN-1:0]  pc_q, pc_n;
   logic             done_n, busy_n;
   logic             hs, load_ok;
   logic [XLEN-1:0]  rd_word;

   assign hs      = valid_q & bus.instr_ready;
   assign load_ok = load_en & (state != RUN);

   always_ff @(posedge clk) begin
      if (load_ok) mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state       <= IDLE;
         idx         <= '0;
         len         <= '0;
         loop_q      <= 1'b0;
         issue_count <= '0;
         valid_q     <= 1'b0;
         instr_q     <= FILL;
         pc_q        <= PC_BASE;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         len         <= len_n;
         loop_q      <= loop_n;
         issue_count <= cnt_n;
         valid_q     <= valid_n;
         instr_q     <= instr_n;
         pc_q        <= pc_n;
         busy        <= busy_n;
         done        <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      len_n   = len;
      loop_n  = loop_q;
      cnt_n   = issue_count;
      case (state)
         IDLE, DONE: begin
            if (stop) begin
               state_n = IDLE;
            end else if (start) begin
               idx_n   = '0;
               cnt_n   = '0;
               loop_n  = loop_mode;
               len_n   = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
               state_n = (prog_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (hs) cnt_n = (&issue_count) ? issue_count : issue_count + CNT_W'(1);
            if (stop) begin
               state_n = IDLE;
            end else if (hs) begin
               if ({1'b0, idx} == len - LEN_ONE) begin
                  idx_n = '0;
                  if (!loop_q) state_n = DONE;
               end else begin
                  idx_n = idx + AW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // A same-cycle load to the entry about to be read must be seen by the first issue.
      rd_word = (load_ok && load_addr == idx_n) ? load_data : mem[idx_n];
      valid_n = (state_n == RUN);
      busy_n  = (state_n == RUN);
      done_n  = (state_n == DONE);
      instr_n = valid_n ? rd_word : FILL;
      pc_n    = valid_n ? PC_BASE + XLEN'({idx_n, 2'b00}) : pc_q;
   end

   assign bus.instr_valid = valid_q;
   assign bus.instruction = instr_q;
   assign bus.issue_pc    = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected issues, a negedge
// monitor pops and compares on every handshake.
module tb_instr_sequencer;
   localparam int XLEN = 32;
   localparam int AW   = 4;

`ifdef NOP_FILL_EN
   localparam logic [31:0] FILL = 32'h0000_0013;
`else
   localparam logic [31:0] FILL = 32'h0000_0000;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic          clk = 1'b0;
   logic          nrst;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;
   logic          start, stop, loop_mode;
   logic [AW:0]   prog_len;
   logic          busy, done;
   logic [15:0]   issue_count;

   int   n_compared   = 0;
   int   n_mismatched = 0;
   exp_t exp_q[$];

   logic [31:0] prog [5] = '{32'h3e800093, 32'h83000113, 32'h3e906193, 32'h45707213, 32'h3f31f213};
   logic        rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   instr_sequencer_if #(.XLEN(XLEN)) bus ();

   instr_sequencer dut (
      .clk        (clk),
      .nrst       (nrst),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .start      (start),
      .stop       (stop),
      .loop_mode  (loop_mode),
      .prog_len   (prog_len),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic sp, input logic lm, input logic [AW:0] len);
      start     = st;
      stop      = sp;
      loop_mode = lm;
      prog_len  = len;
      tick();
      start   = 1'b0;
      stop    = 1'b0;
      load_en = 1'b0;
   endtask

   task automatic loadWord(input logic [AW-1:0] addr, input logic [31:0] data);
      load_en   = 1'b1;
      load_addr = addr;
      load_data = data;
      tick();
      load_en = 1'b0;
   endtask

   task automatic pushProgram(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('{prog[i], 32'(4 * i)});
   endtask

   task automatic waitDone(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (done) break;
         tick();
      end
      checkOutput("done_reached", {31'd0, done}, 32'd1);
   endtask

   // Handshakes pop the scoreboard; a stalled valid must already show the pending word.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (nrst && bus.instr_valid) begin
         if (exp_q.size() == 0) begin
            if (bus.instr_ready) begin
               n_compared++;
               n_mismatched++;
               $display("[TB] FAIL unexpected_issue: got %h at pc %h, expected none", bus.instruction, bus.issue_pc);
            end
         end else if (bus.instr_ready) begin
            e = exp_q.pop_front();
            checkOutput("issue_instr", bus.instruction, e.instr);
            checkOutput("issue_pc", bus.issue_pc, e.pc);
         end else begin
            checkOutput("hold_instr", bus.instruction, exp_q[0].instr);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      nrst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; stop = 1'b0; loop_mode = 1'b0; prog_len = '0;
      bus.instr_ready = 1'b0;
      tick();
      tick();
      checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_count", {16'd0, issue_count}, 32'd0);
      checkOutput("rst_pc", bus.issue_pc, 32'd0);
      checkOutput("rst_fill", bus.instruction, FILL);
      nrst = 1'b1;

      for (int i = 0; i < 5; i++) loadWord(AW'(i), prog[i]);
      checkOutput("idle_fill", bus.instruction, FILL);

      $display("[TB] one-shot playback, ready held high");
      bus.instr_ready = 1'b1;
      pushProgram(5);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd5);
      checkOutput("first_valid", {31'd0, bus.instr_valid}, 32'd1);
      checkOutput("first_busy", {31'd0, busy}, 32'd1);
      waitDone(20);
      checkOutput("oneshot_count", {16'd0, issue_count}, 32'd5);
      checkOutput("oneshot_drained", exp_q.size(), 32'd0);
      checkOutput("done_valid", {31'd0, bus.instr_valid}, 32'd0);

      $display("[TB] one-shot playback, ready pattern 1,0,0,1");
      pushProgram(5);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd5);
      k = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) break;
         bus.instr_ready = rdy_pat[k % 4];
         k++;
         tick();
      end
      checkOutput("stall_done", {31'd0, done}, 32'd1);
      checkOutput("stall_drained_at_done", exp_q.size(), 32'd0);
      checkOutput("stall_count", {16'd0, issue_count}, 32'd5);
      bus.instr_ready = 1'b1;

      $display("[TB] looped playback, stop on 7th handshake");
      for (int i = 0; i < 7; i++) exp_q.push_back('{prog[i % 2], 32'(4 * (i % 2))});
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd2);
      repeat (6) tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd2);
      checkOutput("stop_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("stop_busy", {31'd0, busy}, 32'd0);
      checkOutput("stop_done", {31'd0, done}, 32'd0);
      checkOutput("stop_count", {16'd0, issue_count}, 32'd7);
      checkOutput("stop_drained", exp_q.size(), 32'd0);
      checkOutput("stop_fill", bus.instruction, FILL);

      $display("[TB] zero-length program and start+stop");
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
      checkOutput("len0_done", {31'd0, done}, 32'd1);
      checkOutput("len0_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("len0_count", {16'd0, issue_count}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
      checkOutput("done_to_idle", {31'd0, done}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 5'd5);
      checkOutput("startstop_busy", {31'd0, busy}, 32'd0);
      checkOutput("startstop_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("startstop_done", {31'd0, done}, 32'd0);

      $display("[TB] load during run is ignored, reset mid-run");
      pushProgram(5);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd5);
      load_en = 1'b1; load_addr = '0; load_data = 32'h0000_0013;
      tick();
      load_en = 1'b0;
      waitDone(20);
      pushProgram(5);
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd5);
      tick();
      nrst = 1'b0;
      tick();
      checkOutput("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_count", {16'd0, issue_count}, 32'd0);
      checkOutput("midrst_pc", bus.issue_pc, 32'd0);
      checkOutput("midrst_fill", bus.instruction, FILL);
      exp_q.delete();
      nrst = 1'b1;

      $display("[TB] load and start in the same cycle, single entry");
      exp_q.push_back('{32'h0050_0093, 32'd0});
      load_en = 1'b1; load_addr = '0; load_data = 32'h0050_0093;
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd1);
      waitDone(10);
      checkOutput("bypass_count", {16'd0, issue_count}, 32'd1);
      checkOutput("bypass_drained", exp_q.size(), 32'd0);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
